dsp_fir_dec_ctrl: RTL

Sequencer for the time-multiplexed FIR decimator datapath: one multiplier, one accumulator, one sample RAM and one coefficient ROM. It writes each incoming sample into a circular delay line and counts input samples modulo the decimation ratio. On every R-th sample it walks the taps serially: it drives RAM/ROM addresses and MAC enables, waits for the MAC pipeline to drain, then pulses the accumulator dump that produces one decimated output.

---
 rtl/dsp_fir_dec_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/dsp_fir_dec_ctrl.sv
// dsp_fir_dec_ctrl
// Sequencer for a time-multiplexed FIR decimator (one MAC, one sample RAM,
// one coefficient ROM). Every input sample is written into a circular delay
// line. Every R-th sample starts a serial walk over the taps, then waits
// for the MAC pipeline to drain and pulses acc_dump.
//
// Optional feature: define DSP_FIR_DEC_CTRL_OVR_CNT_EN to add ovr_cnt[7:0],
// which is a saturating count of triggers dropped because a run was busy.
module dsp_fir_dec_ctrl #(
  parameter int TAPS             = 32,
  parameter int R                = 2,
  parameter int CLOCK_PER_SAMPLE = 20,
  parameter int MAC_LAT          = 2,
  parameter int ADDR_W           = 6,
  parameter int CW               = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_val,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [CW-1:0]     coef_addr,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              acc_dump,
  output logic              busy,
  output logic              ovr
`ifdef DSP_FIR_DEC_CTRL_OVR_CNT_EN
  ,
  output logic [7:0]        ovr_cnt
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PH_W  = (R > 1) ? $clog2(R) : 1;
  localparam int FL_W  = $clog2(MAC_LAT + 1);

  // Reject configurations that cannot finish a run in time or that would
  // overwrite taps that are still in use.
  if (TAPS + MAC_LAT + 2 > R * CLOCK_PER_SAMPLE) begin : g_bad_rate
    $error("dsp_fir_dec_ctrl: TAPS+MAC_LAT+2 exceeds R*CLOCK_PER_SAMPLE");
  end
  if (DEPTH < TAPS + R) begin : g_bad_depth
    $error("dsp_fir_dec_ctrl: sample RAM depth smaller than TAPS+R");
  end
  if ((2 ** CW) < TAPS) begin : g_bad_cw
    $error("dsp_fir_dec_ctrl: CW too narrow for TAPS");
  end
  if (R < 1 || MAC_LAT < 1) begin : g_bad_param
    $error("dsp_fir_dec_ctrl: R and MAC_LAT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     k_reg, k_next;
  logic [FL_W-1:0]   fl_reg, fl_next;
  logic [ADDR_W-1:0] n_reg, n_next;
  logic [ADDR_W-1:0] wp_reg;
  logic [PH_W-1:0]   ph_reg;
  logic              trigger;
  logic              drop;

  // A trigger is the sample that completes a group of R. It only starts a
  // run from IDLE, so a trigger that lands in the acc_dump cycle is accepted.
  assign trigger = din_val && (ph_reg == PH_W'(R - 1));
  assign drop    = trigger && (state_reg != IDLE);

  // Write pointer, phase counter and write strobe for the delay line.
  // The write pointer wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_reg  <= '0;
      ph_reg  <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_en <= din_val;
      if (din_val) begin
        wr_addr <= wp_reg;
        wp_reg  <= wp_reg + ADDR_W'(1);
        ph_reg  <= trigger ? '0 : ph_reg + PH_W'(1);
      end
    end
  end

  // FSM state, tap index, flush counter and run base address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      fl_reg    <= '0;
      n_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      fl_reg    <= fl_next;
      n_reg     <= n_next;
    end
  end

  // Next-state logic. The newest sample of the run (n) is the address that
  // gets written while the FSM sits in START.
  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    fl_next    = fl_reg;
    n_next     = n_reg;
    case (state_reg)
      IDLE: begin
        if (trigger) begin
          state_next = START;
          n_next     = wp_reg;
        end
      end
      START: begin
        state_next = RUN;
        k_next     = '0;
      end
      RUN: begin
        if (k_reg == CW'(TAPS - 1)) begin
          state_next = FLUSH;
          fl_next    = '0;
        end else begin
          k_next = k_reg + CW'(1);
        end
      end
      FLUSH: begin
        if (fl_reg == FL_W'(MAC_LAT - 1)) begin
          state_next = IDLE;
        end else begin
          fl_next = fl_reg + FL_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered datapath controls. These are decoded from the next state, so
  // they line up with the state register in the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr   <= '0;
      coef_addr <= '0;
      mac_en    <= 1'b0;
      mac_clr   <= 1'b0;
      acc_dump  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mac_en   <= (state_next == RUN);
      mac_clr  <= (state_next == RUN) && (state_reg == START);
      acc_dump <= (state_reg == FLUSH) && (state_next == IDLE);
      busy     <= (state_next != IDLE);
      if (state_next == RUN) begin
        rd_addr   <= n_next - ADDR_W'(k_next);
        coef_addr <= k_next;
      end else begin
        rd_addr   <= '0;
        coef_addr <= '0;
      end
    end
  end

  // Sticky overrun flag. It is set by any trigger that arrives while a run
  // is busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr <= 1'b0;
    end else if (drop) begin
      ovr <= 1'b1;
    end
  end

`ifdef DSP_FIR_DEC_CTRL_OVR_CNT_EN
  // Saturating count of dropped triggers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_cnt <= '0;
    end else if (drop && (ovr_cnt != 8'hFF)) begin
      ovr_cnt <= ovr_cnt + 8'd1;
    end
  end
`endif

endmodule
